// File: rtl/radio_tx_pkg.sv
// Shared types and default dimensions for the radio transmit scheduler.
package radio_tx_pkg;

  localparam int unsigned LANES_DEFAULT = 8;
  localparam int unsigned LEN_W_DEFAULT = 16;
  localparam int unsigned GAP_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    GAP  = 2'd3
  } txState_t;

  function automatic int unsigned maxW(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/radio_tx_beat_cnt.sv
// Loadable down-counter; term is registered and high while count == 1.
module radio_tx_beat_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk_250m,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] loadVal,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         term
);

  always_ff @(posedge clk_250m) begin
    if (!reset) begin
      count <= '0;
      term  <= 1'b0;
    end else if (load) begin
      count <= loadVal;
      term  <= (loadVal == W'(1));
    end else if (dec) begin
      count <= count - W'(1);
      term  <= (count == W'(2));
    end
  end

endmodule

// File: rtl/radio_tx_sched.sv
// Burst scheduler: gathers masked I/Q lanes into fixed-length bursts with
// optional inter-burst gaps and continuous re-arming.
module radio_tx_sched
  import radio_tx_pkg::*;
#(
  parameter int unsigned LANES = LANES_DEFAULT,
  parameter int unsigned LEN_W = LEN_W_DEFAULT,
  parameter int unsigned GAP_W = GAP_W_DEFAULT
) (
  input  logic             clk_250m,
  input  logic             reset,
  input  logic             cfg_enable,
  input  logic             cfg_start,
  input  logic             cfg_cont,
  input  logic [LANES-1:0] cfg_lane_mask,
  input  logic [LEN_W-1:0] cfg_burst_len,
  input  logic [GAP_W-1:0] cfg_gap,
  input  logic [LANES-1:0] lane_valid,
  input  logic             dac_ready,
  input  logic             err_clr,
  output logic [LANES-1:0] lane_tready,
  output logic             tx_valid,
  output logic             tx_first,
  output logic             tx_last,
  output logic             busy,
  output logic             burst_done,
  output logic [15:0]      burst_count,
  output logic             underrun,
  output logic             cfg_err
);

  localparam int unsigned CNT_W = maxW(LEN_W, GAP_W);

  txState_t         state;
  txState_t         afterBurst;
  logic [LANES-1:0] maskLat;
  logic [LEN_W-1:0] lenLat;
  logic [GAP_W-1:0] gapLat;
  logic             contLat;

  logic             allValid;
  logic             fire;
  logic             lastBeat;
  logic             startOk;
  logic             startBad;
  logic             cntLoad;
  logic             cntDec;
  logic             cntTerm;
  logic [CNT_W-1:0] cntLoadVal;
  logic [CNT_W-1:0] cntVal;

  // The ARM cycle that finds every lane ready is itself beat 0 of the burst.
  always_comb begin
    allValid = &(lane_valid | ~maskLat);
    fire     = dac_ready && allValid &&
               ((state == RUN) || ((state == ARM) && cfg_enable));
    lastBeat = fire && cntTerm;
    startOk  = (state == IDLE) && cfg_start && cfg_enable &&
               (cfg_lane_mask != '0) && (cfg_burst_len != '0);
    startBad = (state == IDLE) && cfg_start &&
               ((cfg_lane_mask == '0) || (cfg_burst_len == '0));

    afterBurst = IDLE;
    if (gapLat != '0)              afterBurst = GAP;
    else if (contLat && cfg_enable) afterBurst = ARM;

    // One counter walks the beats, then the gap, then is reloaded for the next burst.
    cntLoad    = 1'b0;
    cntDec     = 1'b0;
    cntLoadVal = CNT_W'(lenLat);
    if (startOk) begin
      cntLoad    = 1'b1;
      cntLoadVal = CNT_W'(cfg_burst_len);
    end else if (lastBeat) begin
      cntLoad    = 1'b1;
      cntLoadVal = (gapLat != '0) ? CNT_W'(gapLat) : CNT_W'(lenLat);
    end else if ((state == GAP) && cntTerm) begin
      cntLoad    = 1'b1;
    end else begin
      cntDec     = fire || (state == GAP);
    end
  end

  radio_tx_beat_cnt #(.W(CNT_W)) uBeatCnt (
    .clk_250m (clk_250m),
    .reset    (reset),
    .load     (cntLoad),
    .loadVal  (cntLoadVal),
    .dec      (cntDec),
    .count    (cntVal),
    .term     (cntTerm)
  );

  assign lane_tready = fire ? maskLat : '0;
  assign tx_valid    = fire;
  assign tx_first    = fire && (cntVal == CNT_W'(lenLat));
  assign tx_last     = lastBeat;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk_250m) begin
    if (!reset) begin
      state       <= IDLE;
      maskLat     <= '0;
      lenLat      <= '0;
      gapLat      <= '0;
      contLat     <= 1'b0;
      burst_done  <= 1'b0;
      burst_count <= '0;
      underrun    <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      burst_done <= lastBeat;
      if (lastBeat) burst_count <= burst_count + 16'd1;

      // Sticky flags: a new event beats a concurrent clear.
      if ((state == RUN) && dac_ready && !allValid) underrun <= 1'b1;
      else if (err_clr)                              underrun <= 1'b0;
      if (startBad)     cfg_err <= 1'b1;
      else if (err_clr) cfg_err <= 1'b0;

      case (state)
        IDLE: if (startOk) begin
          state   <= ARM;
          maskLat <= cfg_lane_mask;
          lenLat  <= cfg_burst_len;
          gapLat  <= cfg_gap;
          contLat <= cfg_cont;
        end
        ARM: begin
          if (!cfg_enable)   state <= IDLE;
          else if (lastBeat) state <= afterBurst;
          else if (fire)     state <= RUN;
        end
        RUN: if (lastBeat) state <= afterBurst;
        GAP: begin
          if (!cfg_enable)  state <= IDLE;
          else if (cntTerm) state <= contLat ? ARM : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_radio_tx_sched.sv
// Directed bench for radio_tx_sched with a beat scoreboard and per-cycle monitor.
module tb_radio_tx_sched;

  localparam int unsigned LANES = 8;
  localparam int unsigned LEN_W = 16;
  localparam int unsigned GAP_W = 8;

  logic             clk_250m = 1'b0;
  logic             reset;
  logic             cfg_enable;
  logic             cfg_start;
  logic             cfg_cont;
  logic [LANES-1:0] cfg_lane_mask;
  logic [LEN_W-1:0] cfg_burst_len;
  logic [GAP_W-1:0] cfg_gap;
  logic [LANES-1:0] lane_valid;
  logic             dac_ready;
  logic             err_clr;
  logic [LANES-1:0] lane_tready;
  logic             tx_valid;
  logic             tx_first;
  logic             tx_last;
  logic             busy;
  logic             burst_done;
  logic [15:0]      burst_count;
  logic             underrun;
  logic             cfg_err;

  radio_tx_sched #(.LANES(LANES), .LEN_W(LEN_W), .GAP_W(GAP_W)) dut (
    .clk_250m      (clk_250m),
    .reset         (reset),
    .cfg_enable    (cfg_enable),
    .cfg_start     (cfg_start),
    .cfg_cont      (cfg_cont),
    .cfg_lane_mask (cfg_lane_mask),
    .cfg_burst_len (cfg_burst_len),
    .cfg_gap       (cfg_gap),
    .lane_valid    (lane_valid),
    .dac_ready     (dac_ready),
    .err_clr       (err_clr),
    .lane_tready   (lane_tready),
    .tx_valid      (tx_valid),
    .tx_first      (tx_first),
    .tx_last       (tx_last),
    .busy          (busy),
    .burst_done    (burst_done),
    .burst_count   (burst_count),
    .underrun      (underrun),
    .cfg_err       (cfg_err)
  );

  always #2 clk_250m = ~clk_250m;

  typedef struct packed {
    logic             first;
    logic             last;
    logic [LANES-1:0] tready;
  } beat_t;

  beat_t sb[$];
  int    checks    = 0;
  int    errors    = 0;
  int    beatsSeen = 0;
  int    expCount  = 0;
  logic  prevLast  = 1'b0;
  logic  sawValid  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pushBurst(input logic [LANES-1:0] mask, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.first  = (i == 0);
      b.last   = (i == len - 1);
      b.tready = mask;
      sb.push_back(b);
    end
  endtask

  // Called mid-cycle: checks beats against the scoreboard and the done/count model.
  task automatic monitor();
    beat_t e;
    logic  newLast;
    e       = '0;
    newLast = 1'b0;
    if (tx_valid) begin
      beatsSeen++;
      check("beat_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("tx_first", 32'(tx_first), 32'(e.first));
        check("tx_last", 32'(tx_last), 32'(e.last));
        check("lane_tready", 32'(lane_tready), 32'(e.tready));
        newLast = e.last;
      end
    end else begin
      check("idle_tready", 32'(lane_tready), 32'd0);
      check("idle_first_last", 32'({tx_first, tx_last}), 32'd0);
    end
    check("burst_done", 32'(burst_done), 32'(prevLast));
    if (prevLast) expCount++;
    check("burst_count", 32'(burst_count), 32'(expCount[15:0]));
    prevLast = newLast;
    sawValid = tx_valid;
  endtask

  task automatic tick();
    @(negedge clk_250m);
    monitor();
    @(posedge clk_250m);
    if (!reset) begin
      prevLast = 1'b0;
      expCount = 0;
    end
    #1;
  endtask

  task automatic waitIdle(input int budget, input string tag);
    int n;
    n = 0;
    while ((busy !== 1'b0 || sb.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_finished"}, 32'(n < budget), 32'd1);
    tick();
  endtask

  task automatic startPulse();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  initial begin
    int       base;
    int       n;
    logic [6:0] pat;

    // Reset held with an otherwise valid start request present.
    reset         = 1'b0;
    cfg_enable    = 1'b1;
    cfg_start     = 1'b1;
    cfg_cont      = 1'b0;
    cfg_lane_mask = 8'hFF;
    cfg_burst_len = 16'd4;
    cfg_gap       = 8'd0;
    lane_valid    = 8'hFF;
    dac_ready     = 1'b1;
    err_clr       = 1'b0;
    repeat (2) @(posedge clk_250m);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx", 32'({tx_valid, tx_first, tx_last}), 32'd0);
    check("rst_tready", 32'(lane_tready), 32'd0);
    check("rst_done", 32'(burst_done), 32'd0);
    check("rst_count", 32'(burst_count), 32'd0);
    check("rst_flags", 32'({underrun, cfg_err}), 32'd0);
    tick();
    check("rst_hold_busy", 32'(busy), 32'd0);
    cfg_start = 1'b0;
    reset     = 1'b1;
    tick();

    // Reset in the middle of a 16-beat burst.
    cfg_burst_len = 16'd16;
    pushBurst(8'hFF, 16);
    startPulse();
    check("abort_busy", 32'(busy), 32'd1);
    base = beatsSeen;
    n    = 0;
    while (beatsSeen - base < 5 && n < 20) begin
      tick();
      n++;
    end
    check("abort_beats_before", 32'(beatsSeen - base), 32'd5);
    reset = 1'b0;
    tick();
    sb.delete();
    reset = 1'b1;
    check("abort_busy_after", 32'(busy), 32'd0);
    check("abort_tx_after", 32'({tx_valid, tx_first, tx_last}), 32'd0);
    check("abort_tready_after", 32'(lane_tready), 32'd0);
    check("abort_done_after", 32'(burst_done), 32'd0);
    check("abort_count_after", 32'(burst_count), 32'd0);
    tick();
    tick();

    // Basic 4-beat burst, all lanes.
    cfg_burst_len = 16'd4;
    pushBurst(8'hFF, 4);
    base = beatsSeen;
    startPulse();
    waitIdle(20, "basic");
    check("basic_beats", 32'(beatsSeen - base), 32'd4);
    check("basic_count", 32'(burst_count), 32'd1);
    check("basic_underrun", 32'(underrun), 32'd0);

    // Half mask, lane 2 drops out for 3 cycles; unmasked lanes idle throughout.
    cfg_lane_mask = 8'h0F;
    cfg_burst_len = 16'd8;
    lane_valid    = 8'h0F;
    pushBurst(8'h0F, 8);
    base = beatsSeen;
    startPulse();
    repeat (3) tick();
    lane_valid    = 8'h0B;
    cfg_lane_mask = 8'h00;
    cfg_burst_len = 16'd3;
    cfg_start     = 1'b1;
    n = beatsSeen;
    tick();
    cfg_start = 1'b0;
    repeat (2) tick();
    check("stall_no_beats", 32'(beatsSeen - n), 32'd0);
    check("stall_busy", 32'(busy), 32'd1);
    check("stall_underrun", 32'(underrun), 32'd1);
    check("busy_start_no_err", 32'(cfg_err), 32'd0);
    lane_valid = 8'h0F;
    waitIdle(30, "stall");
    check("stall_beats", 32'(beatsSeen - base), 32'd8);
    check("stall_count", 32'(burst_count), 32'd2);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("underrun_cleared", 32'(underrun), 32'd0);

    // Continuous mode with a 3-cycle gap; enable dropped inside the second gap.
    cfg_lane_mask = 8'h03;
    cfg_burst_len = 16'd2;
    cfg_gap       = 8'd3;
    cfg_cont      = 1'b1;
    lane_valid    = 8'hFF;
    pushBurst(8'h03, 2);
    pushBurst(8'h03, 2);
    startPulse();
    pat = '0;
    repeat (7) begin
      tick();
      pat = {pat[5:0], sawValid};
    end
    check("cont_pattern", 32'(pat), 32'(7'b1100011));
    check("cont_in_gap_busy", 32'(busy), 32'd1);
    cfg_enable = 1'b0;
    tick();
    check("cont_gap_abort", 32'(busy), 32'd0);
    check("cont_count", 32'(burst_count), 32'd4);
    check("cont_sb_empty", 32'(sb.size()), 32'd0);
    cfg_enable = 1'b1;
    cfg_cont   = 1'b0;
    cfg_gap    = 8'd0;
    tick();

    // Rejected starts raise cfg_err; a clear concurrent with a new error loses.
    cfg_lane_mask = 8'h00;
    cfg_burst_len = 16'd4;
    startPulse();
    check("err_mask_busy", 32'(busy), 32'd0);
    check("err_mask_flag", 32'(cfg_err), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_cleared", 32'(cfg_err), 32'd0);
    cfg_lane_mask = 8'hFF;
    cfg_burst_len = 16'd0;
    err_clr       = 1'b1;
    startPulse();
    err_clr = 1'b0;
    check("err_len_busy", 32'(busy), 32'd0);
    check("err_set_wins", 32'(cfg_err), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_cleared2", 32'(cfg_err), 32'd0);

    // Single-beat burst with a toggling DAC ready.
    cfg_burst_len = 16'd1;
    dac_ready     = 1'b0;
    pushBurst(8'hFF, 1);
    base = beatsSeen;
    startPulse();
    n = 0;
    while ((busy !== 1'b0 || sb.size() != 0) && n < 20) begin
      dac_ready = ~dac_ready;
      tick();
      n++;
    end
    check("single_finished", 32'(n < 20), 32'd1);
    tick();
    check("single_beats", 32'(beatsSeen - base), 32'd1);
    check("single_underrun", 32'(underrun), 32'd0);
    check("single_count", 32'(burst_count), 32'd5);

    check("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/radio_tx_sched.md
RADIO_TX_SCHED -- requirements
Module: radio_tx_sched

Interface
REQ-001 Parameter LANES, default 8, number of parallel I/Q transmit lanes.
REQ-002 Parameter LEN_W, default 16, burst-length width in beats.
REQ-003 Parameter GAP_W, default 8, inter-burst gap width in cycles.
REQ-004 clk_250m  in  1  sole clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-low reset (0 = reset asserted).
REQ-006 cfg_enable  in  1  scheduler enable; level.
REQ-007 cfg_start  in  1  single-cycle burst start request.
REQ-008 cfg_cont  in  1  continuous mode: re-arm automatically after each burst.
REQ-009 cfg_lane_mask  in  LANES  lanes taking part in a burst.
REQ-010 cfg_burst_len  in  LEN_W  beats per burst.
REQ-011 cfg_gap  in  GAP_W  idle cycles between bursts.
REQ-012 lane_valid  in  LANES  per-lane upstream tvalid (I AND Q).
REQ-013 dac_ready  in  1  downstream DAC path ready.
REQ-014 lane_tready  out  LANES  per-lane tready to the I/Q sources.
REQ-015 tx_valid / tx_first / tx_last  out  1 each  burst beat strobe, first beat, final beat.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 burst_done  out  1  one-cycle pulse after the final beat.
REQ-018 burst_count  out  16  completed bursts, wraps 0xFFFF->0.
REQ-019 underrun / cfg_err  out  1 each  sticky flags; err_clr (in, 1) clears both.

Function
REQ-020 FSM states SHALL be IDLE, ARM, RUN, GAP.
REQ-021 IDLE->ARM on cfg_start=1 with cfg_enable=1, mask!=0, len!=0; cfg_lane_mask/len/gap/cont latched that cycle.
REQ-022 cfg_start with mask==0 or len==0 SHALL be ignored and set cfg_err.
REQ-023 ARM->RUN when every masked lane has lane_valid=1 and dac_ready=1; that cycle is beat 0.
REQ-024 A beat fires when state==RUN, dac_ready=1 and all masked lane_valid=1; lane_tready = latched mask on a firing cycle, else 0.
REQ-025 tx_valid SHALL equal beat-fire, combinational, zero latency from inputs; tx_first on beat 0, tx_last on beat len-1.
REQ-026 In RUN, dac_ready=1 with any masked lane_valid=0 SHALL stall (no beat) and set underrun; dac_ready=0 stalls silently.
REQ-027 Unmasked lanes SHALL never see lane_tready=1.
REQ-028 After final beat: ->GAP if gap!=0, else ->ARM if latched cont and cfg_enable, else ->IDLE.
REQ-029 GAP SHALL last exactly latched gap cycles, then ->ARM (cont and cfg_enable) or ->IDLE.
REQ-030 burst_done pulses and burst_count increments on the cycle after the final beat.
REQ-031 cfg_enable=0 during RUN SHALL let the burst finish; in ARM or GAP it SHALL force IDLE next cycle.
REQ-032 cfg_start outside IDLE SHALL be ignored, no error flag.
REQ-033 len==1: tx_first and tx_last SHALL assert on the same beat.
REQ-034 Latched config SHALL not change until the next IDLE->ARM transition.
REQ-035 err_clr concurrent with a new error event: the set SHALL win.

Reset
REQ-036 With reset=0 at a clock edge: state=IDLE, counters=0, latched config=0, all outputs 0.
REQ-037 Reset mid-burst SHALL abort immediately; no burst_done, no burst_count increment.

Structure
REQ-038 Shared package radio_tx_pkg SHALL hold the state enum and LANES/LEN_W/GAP_W defaults.
REQ-039 One sub-module, radio_tx_beat_cnt (loadable down-counter with terminal flag), SHALL serve both beat and gap counting.

Verification
REQ-040 mask=0xFF, len=4, gap=0, all valid, dac_ready=1, start -> 4 beats, tx_first beat0, tx_last beat3, burst_done next cycle, count=1.
REQ-041 mask=0x0F, len=8, lane_valid[2] low 3 cycles mid-burst -> 3-cycle stall, underrun=1, lane_tready[7:4] always 0, 8 beats total.
REQ-042 cont=1, len=2, gap=3 -> beats separated by exactly 3 idle cycles; deassert enable in GAP -> IDLE next cycle.
REQ-043 start with mask=0 -> stays IDLE, cfg_err=1; err_clr -> cfg_err=0.
REQ-044 reset=0 at beat 5 of len=16 -> all outputs 0 next cycle, burst_count unchanged.
REQ-045 len=1 with dac_ready toggling every cycle -> single beat with tx_first=tx_last=1, no underrun.
